mem_request_unit: RTL and testbench

Data-memory initiator between the single-cycle core's load/store path and the word-addressed RAM. It accepts one load or store at a time from the core and stalls the core while the request is in flight. It drives the RAM read/write enables and handles byte and halfword accesses: loads are extracted with sign or zero extension, and sub-word stores use read-modify-write. It sequences accesses to match the RAM's one-cycle registered read and its IDLE/WAIT recovery.

---
 rtl/mem_req_pkg.sv | 39 +++
 rtl/mem_request_unit_if.sv | 36 +++
 rtl/mem_lane_align.sv | 50 +++++
 rtl/mem_request_unit.sv | 116 +++++++++++
 tb/tb_mem_request_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_pkg.sv
// Shared types for the data-memory request unit.
// Holds the FSM state enum, RV32I size codes and the request decode helper.
package mem_req_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_WR_WAIT = 3'd4,
    S_DONE    = 3'd5
  } mreq_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 1 = misaligned address or funct3 not legal
  // for this direction (stores have no BU/HU).
  function automatic logic req_err(
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic e;
    unique case (1'b1)
      f3 == F3_B:  e = 1'b0;
      f3 == F3_BU: e = wr;
      f3 == F3_H:  e = a[0];
      f3 == F3_HU: e = wr | a[0];
      f3 == F3_W:  e = (a != 2'b00);
      default:     e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mem_request_unit_if.sv
// Core request/response and RAM bus bundle of mem_request_unit.
// slave: the request unit; master: core plus RAM side.
interface mem_request_unit_if;

  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] load_data;
  logic [11:0] mem_addr;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata, mem_rdata,
    output stall, resp_valid, resp_error,
    output load_data, mem_addr, mem_wdata,
    output mem_read_enable, mem_write_enable
  );

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata, mem_rdata,
    input  stall, resp_valid, resp_error,
    input  load_data, mem_addr, mem_wdata,
    input  mem_read_enable, mem_write_enable
  );

endinterface

// File: rtl/mem_lane_align.sv
// Load lane extract/extend and sub-word store merge.
// In: funct3_i, addr_i, rdata_i, wdata_i; out: load_o, merged_o.
module mem_lane_align
  import mem_req_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] mrg_b;
  logic [31:0] mrg_h;

  always_comb begin
    sh_b   = {addr_i, 3'b000};
    sh_h   = {addr_i[1], 4'b0000};
    lane_b = 8'(rdata_i >> sh_b);
    lane_h = 16'(rdata_i >> sh_h);
    mrg_b  = (rdata_i & ~(32'h0000_00ff << sh_b))
           | ({24'd0, wdata_i[7:0]} << sh_b);
    mrg_h  = (rdata_i & ~(32'h0000_ffff << sh_h))
           | ({16'd0, wdata_i[15:0]} << sh_h);
  end

  always_comb begin
    load_o   = rdata_i;
    merged_o = wdata_i;
    unique case (1'b1)
      funct3_i == F3_B: begin
        load_o   = {{24{lane_b[7]}}, lane_b};
        merged_o = mrg_b;
      end
      funct3_i == F3_H: begin
        load_o   = {{16{lane_h[15]}}, lane_h};
        merged_o = mrg_h;
      end
      funct3_i == F3_BU: load_o = {24'd0, lane_b};
      funct3_i == F3_HU: load_o = {16'd0, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_request_unit.sv
// Data-memory initiator: one load/store at a time, RMW sub-word stores.
// Ports: clk, nRst (async active-low), bus (slave modport).
module mem_request_unit
  import mem_req_pkg::*;
(
  input  logic                clk,
  input  logic                nRst,
  mem_request_unit_if.slave   bus
);

  mreq_state_t state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_q, load_d;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;
  logic        new_err;

  mem_lane_align u_align (
    .funct3_i (f3_q),
    .addr_i   (addr_q[1:0]),
    .rdata_i  (bus.mem_rdata),
    .wdata_i  (wdata_q),
    .load_o   (lane_load),
    .merged_o (lane_merged)
  );

  assign new_err = req_err(bus.req_write,
                           bus.req_funct3,
                           bus.req_addr[1:0]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    write_d = write_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          f3_d    = bus.req_funct3;
          write_d = bus.req_write;
          wdata_d = bus.req_wdata;
          err_d   = new_err;
          if (new_err)
            state_d = S_DONE;
          else if (bus.req_write &&
                   bus.req_funct3 == F3_W)
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        // wdata_q becomes the merged word so WR
        // drives one register for both store kinds
        if (write_q) begin
          wdata_d = lane_merged;
          state_d = S_WR;
        end else begin
          load_d  = lane_load;
          state_d = S_DONE;
        end
      end
      S_WR:      state_d = S_WR_WAIT;
      S_WR_WAIT: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      write_q <= write_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

  // stall drops in DONE so the core retires there
  assign bus.stall = (state_q == S_IDLE)
                   ? bus.req_valid
                   : (state_q != S_DONE);

  assign bus.mem_read_enable  = (state_q == S_RD);
  assign bus.mem_write_enable = (state_q == S_WR);
  assign bus.resp_valid       = (state_q == S_DONE);
  assign bus.resp_error       = (state_q == S_DONE) & err_q;
  assign bus.load_data        = load_q;
  assign bus.mem_addr  = (state_q == S_IDLE)
                       ? 12'd0
                       : {addr_q[11:2], 2'b00};
  assign bus.mem_wdata = (state_q == S_WR)
                       ? wdata_q
                       : 32'd0;

endmodule

// File: tb/tb_mem_request_unit.sv
// Scoreboard bench for mem_request_unit with a registered-read RAM.
// Expected responses are queued at drive time and popped on completion.
module tb_mem_request_unit;
  import mem_req_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] ld;
    logic [15:0] rd;
    logic [15:0] wr;
    logic [15:0] st;
    int          rc;
    logic [31:0] wd;
  } res_t;

  logic clk = 1'b0;
  logic nRst;
  bit   ram_load;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  logic [31:0] ld_model;
  logic [31:0] ram [0:1023];
  res_t exp_q [$];

  mem_request_unit_if bus ();

  mem_request_unit dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'd0;
      ram[4] <= 32'h8899_AABB;
      bus.mem_rdata <= 32'd0;
    end else begin
      if (bus.mem_read_enable)
        bus.mem_rdata <= ram[bus.mem_addr[11:2]];
      if (bus.mem_write_enable)
        ram[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end
  end

  always @(posedge clk)
    if (bus.mem_write_enable) wr_cnt <= wr_cnt + 1;

  function automatic res_t mk(
    input logic er, input logic [31:0] ld,
    input logic [15:0] rd, input logic [15:0] wr,
    input int rc, input logic [31:0] wd
  );
    res_t r;
    r.err = er; r.ld = ld; r.rd = rd; r.wr = wr;
    r.rc = rc;  r.wd = wd;
    r.st = 16'((32'd1 << rc) - 32'd1);
    return r;
  endfunction

  task automatic run_req(
    input logic w, input logic [2:0] f3,
    input logic [11:0] a, input logic [31:0] d,
    output res_t o
  );
    o.err = 1'b0; o.ld = '0; o.rd = '0;
    o.wr = '0; o.st = '0; o.rc = -1; o.wd = '0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (bus.mem_read_enable) o.rd[c] = 1'b1;
      if (bus.mem_write_enable) begin
        o.wr[c] = 1'b1;
        o.wd = bus.mem_wdata;
      end
      if (bus.stall) o.st[c] = 1'b1;
      if (bus.resp_valid) begin
        o.rc  = c;
        o.err = bus.resp_error;
        o.ld  = bus.load_data;
        break;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    if ({bus.resp_valid, bus.resp_error,
         bus.mem_read_enable, bus.mem_write_enable,
         bus.stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 00000",
        {bus.resp_valid, bus.resp_error,
         bus.mem_read_enable, bus.mem_write_enable,
         bus.stall});
    end
    checks++;
    if (bus.mem_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset_addr got %h want 000",
        bus.mem_addr);
    end
    checks++;
    if (bus.mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_wdata got %h want 0",
        bus.mem_wdata);
    end
    checks++;
    if (bus.load_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_ld got %h want 0",
        bus.load_data);
    end
    checks++;
    bus.req_valid = 1'b1;
    #1;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall got %b want 1",
        bus.stall);
    end
    checks++;
    bus.req_valid = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    ld_model = 32'd0;
  endtask

  task automatic test_loads;
    logic [11:0] ad [5] = '{12'h010, 12'h011,
                            12'h011, 12'h012, 12'h012};
    logic [2:0]  f  [5] = '{F3_W, F3_B, F3_BU,
                            F3_H, F3_HU};
    logic [31:0] v  [5] = '{32'h8899_AABB,
                            32'hFFFF_FFAA,
                            32'h0000_00AA,
                            32'hFFFF_8899,
                            32'h0000_8899};
    res_t e, o;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(1'b0, v[i], 16'h2, 16'h0,
                         3, 32'd0));
      ld_model = v[i];
      run_req(1'b0, f[i], ad[i], 32'd0, o);
      e = exp_q.pop_front();
      if (o.rc !== e.rc) begin
        errors++;
        $display("FAIL load%0d resp_cyc got %0d want %0d",
          i, o.rc, e.rc);
      end
      checks++;
      if ({o.err, o.ld} !== {e.err, e.ld}) begin
        errors++;
        $display("FAIL load%0d err/data got %b/%h want %b/%h",
          i, o.err, o.ld, e.err, e.ld);
      end
      checks++;
      if ({o.rd, o.wr, o.st} !== {e.rd, e.wr, e.st}) begin
        errors++;
        $display("FAIL load%0d rd/wr/stall got %h/%h/%h want %h/%h/%h",
          i, o.rd, o.wr, o.st, e.rd, e.wr, e.st);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid;
    res_t e, o;
    int w0;
    w0 = wr_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = F3_H;
    bus.req_addr   = 12'h010;
    bus.req_wdata  = 32'h0000_CAFE;
    repeat (2) @(negedge clk);
    #2;
    nRst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    if ({bus.resp_valid, bus.resp_error,
         bus.mem_read_enable, bus.mem_write_enable,
         bus.stall} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_ctl got %b want 00000",
        {bus.resp_valid, bus.resp_error,
         bus.mem_read_enable, bus.mem_write_enable,
         bus.stall});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.load_data}
        !== 76'd0) begin
      errors++;
      $display("FAIL midrst_bus got %h/%h/%h want zeros",
        bus.mem_addr, bus.mem_wdata, bus.load_data);
    end
    checks++;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    ld_model = 32'd0;
    repeat (3) @(negedge clk);
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL midrst_writes got %0d want %0d",
        wr_cnt, w0);
    end
    checks++;
    if (ram[4] !== 32'h8899_AABB) begin
      errors++;
      $display("FAIL midrst_word got %h want 8899aabb",
        ram[4]);
    end
    checks++;
    exp_q.push_back(mk(1'b0, 32'h8899_AABB, 16'h2,
                       16'h0, 3, 32'd0));
    ld_model = 32'h8899_AABB;
    run_req(1'b0, F3_W, 12'h010, 32'd0, o);
    e = exp_q.pop_front();
    if ({o.rc, o.err, o.ld} !== {e.rc, e.err, e.ld}) begin
      errors++;
      $display("FAIL midrst_lw got %0d/%b/%h want %0d/%b/%h",
        o.rc, o.err, o.ld, e.rc, e.err, e.ld);
    end
    checks++;
    if ({o.rd, o.wr, o.st} !== {e.rd, e.wr, e.st}) begin
      errors++;
      $display("FAIL midrst_lw_en got %h/%h/%h want %h/%h/%h",
        o.rd, o.wr, o.st, e.rd, e.wr, e.st);
    end
    checks++;
  endtask

  task automatic test_stores;
    logic        w  [7] = '{1'b1, 1'b0, 1'b1, 1'b0,
                            1'b1, 1'b0, 1'b0};
    logic [2:0]  f  [7] = '{F3_B, F3_W, F3_W, F3_W,
                            F3_H, F3_HU, F3_H};
    logic [11:0] ad [7] = '{12'h013, 12'h010, 12'h020,
                            12'h020, 12'h022, 12'h022,
                            12'h020};
    logic [31:0] d  [7] = '{32'h1234_5677, 32'd0,
                            32'hDEAD_BEEF, 32'd0,
                            32'h5555_CAFE, 32'd0, 32'd0};
    logic [31:0] v  [7] = '{32'h7799_AABB,
                            32'h7799_AABB,
                            32'hDEAD_BEEF,
                            32'hDEAD_BEEF,
                            32'hCAFE_BEEF,
                            32'h0000_CAFE,
                            32'hFFFF_BEEF};
    res_t e, o;
    for (int i = 0; i < 7; i++) begin
      if (!w[i]) begin
        exp_q.push_back(mk(1'b0, v[i], 16'h2, 16'h0,
                           3, 32'd0));
        ld_model = v[i];
      end else if (f[i] == F3_W)
        exp_q.push_back(mk(1'b0, ld_model, 16'h0,
                           16'h2, 3, v[i]));
      else
        exp_q.push_back(mk(1'b0, ld_model, 16'h2,
                           16'h8, 5, v[i]));
      run_req(w[i], f[i], ad[i], d[i], o);
      e = exp_q.pop_front();
      if (o.rc !== e.rc) begin
        errors++;
        $display("FAIL st%0d resp_cyc got %0d want %0d",
          i, o.rc, e.rc);
      end
      checks++;
      if ({o.err, o.ld} !== {e.err, e.ld}) begin
        errors++;
        $display("FAIL st%0d err/data got %b/%h want %b/%h",
          i, o.err, o.ld, e.err, e.ld);
      end
      checks++;
      if ({o.rd, o.wr, o.st} !== {e.rd, e.wr, e.st}) begin
        errors++;
        $display("FAIL st%0d rd/wr/stall got %h/%h/%h want %h/%h/%h",
          i, o.rd, o.wr, o.st, e.rd, e.wr, e.st);
      end
      checks++;
      if (e.wr != 16'h0) begin
        if (o.wd !== e.wd) begin
          errors++;
          $display("FAIL st%0d wdata got %h want %h",
            i, o.wd, e.wd);
        end
        checks++;
      end
    end
  endtask

  task automatic test_errors;
    logic        w  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f  [3] = '{F3_W, F3_H, 3'b011};
    logic [11:0] ad [3] = '{12'h012, 12'h011, 12'h010};
    res_t e, o;
    int w0;
    for (int i = 0; i < 3; i++) begin
      w0 = wr_cnt;
      exp_q.push_back(mk(1'b1, ld_model, 16'h0, 16'h0,
                         1, 32'd0));
      run_req(w[i], f[i], ad[i], 32'h0BAD_F00D, o);
      e = exp_q.pop_front();
      if ({o.rc, o.err} !== {e.rc, e.err}) begin
        errors++;
        $display("FAIL err%0d cyc/err got %0d/%b want %0d/%b",
          i, o.rc, o.err, e.rc, e.err);
      end
      checks++;
      if ({o.rd, o.wr, o.st} !== {e.rd, e.wr, e.st}) begin
        errors++;
        $display("FAIL err%0d rd/wr/stall got %h/%h/%h want %h/%h/%h",
          i, o.rd, o.wr, o.st, e.rd, e.wr, e.st);
      end
      checks++;
      if (bus.load_data !== e.ld || wr_cnt !== w0) begin
        errors++;
        $display("FAIL err%0d ld/writes got %h/%0d want %h/%0d",
          i, bus.load_data, wr_cnt, e.ld, w0);
      end
      checks++;
    end
  endtask

  initial begin
    nRst = 1'b0;
    ram_load = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 12'd0;
    bus.req_wdata  = 32'd0;
    ld_model = 32'd0;
    repeat (2) @(negedge clk);
    ram_load = 1'b0;
    test_reset;
    test_loads;
    test_reset_mid;
    test_stores;
    test_errors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
